// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS32 core: PC/IF/ID/ID-EX enables,
// mult/div busy tracking, and a saturating stall-cycle counter.
//
// state   | meaning
// MD_IDLE | mult/div unit free; an unstalled id_md_start issues this cycle
// MD_RUN  | mult/div in flight; md_cnt counts down to the final busy cycle
module hazard_ctrl #(
  parameter int MD_CYCLES = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_md_start,
  input  logic             id_md_use,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             md_issue,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_RUN  = 1'b1;

  localparam logic [7:0]       MD_LOAD = 8'(MD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]       state;
  logic [7:0]       md_cnt;
  logic [CNT_W-1:0] stall_q;

  logic running;
  logic flush;
  logic lu;
  logic mdh;

  assign running = (state == MD_RUN);
  assign flush   = ex_branch_taken | ex_jump;
  assign lu      = ex_MemRead & (ex_rt != 5'd0) &
                   ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign mdh     = id_md_use & running;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    md_issue    = 1'b0;
    md_busy     = 1'b0;
    md_done     = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      md_busy  = running;
      md_done  = running & (md_cnt == 8'd0);
      md_issue = id_md_start & ~flush & ~lu & ~mdh;
      if (flush) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (lu | mdh) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  // A branch flush never cancels an in-flight op: it issued before the branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= MD_IDLE;
      md_cnt <= 8'd0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (md_issue) begin
            state  <= MD_RUN;
            md_cnt <= MD_LOAD;
          end
        end
        MD_RUN: begin
          if (md_cnt == 8'd0) state <= MD_IDLE;
          else                md_cnt <= md_cnt - 8'd1;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (!pc_write && (stall_q != CNT_MAX)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage MIPS32 core.
- Decides each cycle whether PC and IF/ID advance, hold or flush, and whether the ID/EX register loads the decoded instruction or a bubble with all control fields zeroed.
- Covers three cases: load-use hazards, taken branches and jumps resolved in EX, and a multi-cycle mult/div unit whose HI/LO consumers must wait.
- Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MD_CYCLES, 8, cycles the mult/div unit stays busy after issue (legal range 2..255).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- id_md_start  in  1  ID instruction is mult/multu/div/divu.
- id_md_use  in  1  ID instruction reads HI/LO (mfhi/mflo) or is itself a mult/div.
- ex_MemRead  in  1  MemRead field currently in ID/EX.
- ex_rt  in  5  inst[20:16] field currently in ID/EX (load destination).
- ex_branch_taken  in  1  EX stage resolved a taken branch this cycle.
- ex_jump  in  1  EX stage holds a jump this cycle.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_bubble  out  1  ID/EX loads zeros on every control field.
- md_issue  out  1  one-cycle pulse: the mult/div unit starts this cycle.
- md_busy  out  1  mult/div unit is busy.
- md_done  out  1  one-cycle pulse on the final busy cycle.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0.

Behaviour:
- State:
  - md_cnt: 8-bit down-counter.
  - FSM: MD_IDLE, MD_RUN.
  - stall_cycles register.
- Outputs are combinational from the current inputs and the registered state; zero-latency decisions within the same cycle.
- While reset=1, outputs are forced:
  - pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1.
  - md_issue=0, md_busy=0, md_done=0.
- At the clock edge with reset=1: FSM←MD_IDLE, md_cnt←0, stall_cycles←0. Reset asserted during MD_RUN aborts the operation with no md_done pulse.
- Hazard terms:
  - flush = ex_branch_taken | ex_jump.
  - lu = ex_MemRead & (ex_rt≠0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
  - mdh = id_md_use & md_busy.
- Priority is flush > lu > mdh > normal:
  - flush: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1. Any ID-stage mult/div is discarded (no issue).
  - lu or mdh: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1.
  - normal: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- md_issue = id_md_start & ~flush & ~lu & ~mdh. Because id_md_start implies id_md_use, a new mult/div cannot issue while md_busy=1.
- FSM transitions:
  - MD_IDLE: on md_issue go to MD_RUN, md_cnt←MD_CYCLES−1.
  - MD_RUN: md_busy=1; md_cnt decrements each cycle. When md_cnt==0, md_done=1 and the next state is MD_IDLE.
  - md_busy is high for exactly MD_CYCLES cycles, starting the cycle after md_issue.
  - A HI/LO reader stalled by mdh proceeds in the cycle after md_done.
- Flush during MD_RUN does not cancel the in-flight operation, since it issued before the branch.
- stall_cycles increments by 1 each non-reset cycle with pc_write=0 and saturates at 2^CNT_W−1.
- No internal storage of register numbers; the block relies on ID/EX contents being presented in the same cycle.

Test Plan:
- Load-use on rs: ex_MemRead=1, ex_rt=5, id_rs=5, 1 cycle → pc_write=0, ifid_write=0, idex_bubble=1, stall_cycles 0→1. The next cycle with ex_MemRead=0 returns to normal.
- Load to $zero: ex_MemRead=1, ex_rt=0, id_rs=0 → no stall, idex_bubble=0. Also ex_rt=7, id_rt=7, id_uses_rt=0 → no stall.
- Flush priority: ex_branch_taken=1 together with a lu condition → pc_write=1, ifid_flush=1, idex_bubble=1, stall_cycles unchanged. The same with ex_jump=1.
- Mult/div timing with MD_CYCLES=8:
  - id_md_start=1 at cycle T → md_issue at T.
  - md_busy is high for T+1..T+8, md_done at T+8.
  - mfhi in ID from T+1 stalls 8 cycles, then advances at T+9; stall_cycles=8.
- Issue suppression: id_md_start=1 with ex_branch_taken=1 → md_issue=0 and FSM stays MD_IDLE. id_md_start=1 during an lu stall → issue is deferred to the first unstalled cycle.
- Reset mid-operation: reset=1 at busy cycle 3 → next cycle md_busy=0 with no md_done pulse; stall_cycles=0. Saturation: CNT_W=4 with 20 stalled cycles → stall_cycles=15.
